// File: rtl/mux5_sched.sv
// mux5_sched: round-robin scheduler sharing a 5-way mux among five requesters.
// Define MUX5_SCHED_FIXED_PRIO_EN for fixed priority (i_req[0] highest, no rr pointer).
module mux5_sched #(
   parameter int HOLD_CYCLES = 2,
   parameter int DATA_W      = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [4:0]        i_req,
   input  logic [DATA_W-1:0] i_mux_data,
   output logic [2:0]        o_cntr,
   output logic [4:0]        o_grant,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SELECT = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   // Zero is treated as one; anything above the 4-bit range saturates.
   localparam logic [3:0] HOLD_INIT =
      (HOLD_CYCLES <= 1)  ? 4'd0  :
      (HOLD_CYCLES >= 15) ? 4'd14 :
      4'(HOLD_CYCLES - 1);

   logic [1:0] state;
   logic [3:0] hold_cnt;
   logic [2:0] ptr;
   logic [2:0] win;
   logic       win_vld;

   function automatic logic [2:0] wrap5(input logic [3:0] v);
      return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
   endfunction

   // Scan downward so the lowest offset from the pointer wins.
   always_comb begin
      win     = 3'd0;
      win_vld = 1'b0;
      for (int i = 4; i >= 0; i--) begin
         if (i_req[wrap5({1'b0, ptr} + 4'(i))]) begin
            win     = wrap5({1'b0, ptr} + 4'(i));
            win_vld = 1'b1;
         end
      end
   end

`ifdef MUX5_SCHED_FIXED_PRIO_EN
   assign ptr = 3'd0;
`else
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ptr <= 3'd0;
      end else if (state == DONE) begin
         ptr <= (o_cntr == 3'd4) ? 3'd0 : o_cntr + 3'd1;
      end
   end
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state    <= IDLE;
         hold_cnt <= 4'd0;
         o_cntr   <= 3'd0;
         o_grant  <= 5'd0;
         o_data   <= '0;
         o_valid  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (win_vld) begin
                  o_cntr   <= win;
                  o_grant  <= 5'b00001 << win;
                  hold_cnt <= HOLD_INIT;
                  state    <= SELECT;
               end
            end
            SELECT: begin
               if (hold_cnt != 4'd0) begin
                  hold_cnt <= hold_cnt - 4'd1;
               end else begin
                  o_data  <= i_mux_data;
                  o_valid <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               o_valid <= 1'b0;
               o_grant <= 5'd0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign o_busy = (state != IDLE);

endmodule
